// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared constants, state encoding and address helper for the MVM controller
package mvm_pkg;

  localparam int N           = 3;
  localparam int X_DEPTH     = 9;
  localparam int X_AW        = 4;
  localparam int V_AW        = 2;
  localparam int MAC_LAT_DEF = 2;
  localparam int DLY_W       = 3;

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_A,
    MAC,
    DRAIN,
    WRITE_Y,
    OUT_ADDR,
    OUT_HOLD
  } state_t;

  // Row-major x address for element (row, col) of the 3x3 matrix.
  function automatic logic [X_AW-1:0] x_index(input logic [V_AW-1:0] row,
                                              input logic [V_AW-1:0] col);
    return X_AW'(row) * X_AW'(N) + X_AW'(col);
  endfunction

endpackage

// File: rtl/mvm_controller_if.sv
// rtl/mvm_controller_if.sv - handshake and memory-control bundle between controller and DataPath
interface mvm_controller_if;
  import mvm_pkg::*;

  logic            s_valid;
  logic            s_ready;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
  logic [X_AW-1:0] addr_x;
  logic            wr_en_x;
  logic [V_AW-1:0] addr_a;
  logic            wr_en_a;
  logic [V_AW-1:0] addr_y;
  logic            wr_en_y;
  logic            clear_acc;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, busy, addr_x, wr_en_x, addr_a, wr_en_a,
           addr_y, wr_en_y, clear_acc
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, busy, addr_x, wr_en_x, addr_a, wr_en_a,
           addr_y, wr_en_y, clear_acc
  );

endinterface

// File: rtl/mvm_controller.sv
// rtl/mvm_controller.sv - sequences load, 3x3 matrix-vector MAC and result readout for the DataPath
module mvm_controller
  import mvm_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mvm_controller_if.master   bus
);

  localparam logic [DLY_W-1:0] WIN_LO = DLY_W'(MAC_LAT);
  localparam logic [DLY_W-1:0] WIN_HI = DLY_W'(MAC_LAT + 2);

  state_t           r_state,   w_nxt_state;
  logic [X_AW-1:0]  r_in_cnt,  w_nxt_in_cnt;
  logic [V_AW-1:0]  r_row,     w_nxt_row;
  logic [V_AW-1:0]  r_col,     w_nxt_col;
  logic [V_AW-1:0]  r_out_cnt, w_nxt_out_cnt;
  logic [DLY_W-1:0] r_cyc,     w_nxt_cyc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= LOAD_X;
      r_in_cnt  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_out_cnt <= '0;
      r_cyc     <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_in_cnt  <= w_nxt_in_cnt;
      r_row     <= w_nxt_row;
      r_col     <= w_nxt_col;
      r_out_cnt <= w_nxt_out_cnt;
      r_cyc     <= w_nxt_cyc;
    end
  end

  // r_cyc counts cycles since the row's first MAC cycle; it paces the accumulate window.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_in_cnt  = r_in_cnt;
    w_nxt_row     = r_row;
    w_nxt_col     = r_col;
    w_nxt_out_cnt = r_out_cnt;
    w_nxt_cyc     = r_cyc;
    case (r_state)
      LOAD_X: if (bus.s_valid) begin
        if (r_in_cnt == X_AW'(X_DEPTH - 1)) begin
          w_nxt_state  = LOAD_A;
          w_nxt_in_cnt = '0;
        end else begin
          w_nxt_in_cnt = r_in_cnt + X_AW'(1);
        end
      end
      LOAD_A: if (bus.s_valid) begin
        if (r_in_cnt == X_AW'(N - 1)) begin
          w_nxt_state  = MAC;
          w_nxt_in_cnt = '0;
          w_nxt_row    = '0;
          w_nxt_col    = '0;
          w_nxt_cyc    = '0;
        end else begin
          w_nxt_in_cnt = r_in_cnt + X_AW'(1);
        end
      end
      MAC: begin
        w_nxt_cyc = r_cyc + DLY_W'(1);
        if (r_col == V_AW'(N - 1)) begin
          w_nxt_state = DRAIN;
        end else begin
          w_nxt_col = r_col + V_AW'(1);
        end
      end
      DRAIN: begin
        w_nxt_cyc = r_cyc + DLY_W'(1);
        if (r_cyc == WIN_HI) w_nxt_state = WRITE_Y;
      end
      WRITE_Y: begin
        if (r_row == V_AW'(N - 1)) begin
          w_nxt_state   = OUT_ADDR;
          w_nxt_out_cnt = '0;
        end else begin
          w_nxt_state = MAC;
          w_nxt_row   = r_row + V_AW'(1);
          w_nxt_col   = '0;
          w_nxt_cyc   = '0;
        end
      end
      OUT_ADDR: w_nxt_state = OUT_HOLD;
      OUT_HOLD: if (bus.m_ready) begin
        if (r_out_cnt == V_AW'(N - 1)) begin
          w_nxt_state   = LOAD_X;
          w_nxt_out_cnt = '0;
        end else begin
          w_nxt_state   = OUT_ADDR;
          w_nxt_out_cnt = r_out_cnt + V_AW'(1);
        end
      end
      default: w_nxt_state = LOAD_X;
    endcase
  end

  always_comb begin
    bus.s_ready   = 1'b0;
    bus.m_valid   = 1'b0;
    bus.busy      = !((r_state == LOAD_X) && (r_in_cnt == '0));
    bus.addr_x    = '0;
    bus.wr_en_x   = 1'b0;
    bus.addr_a    = '0;
    bus.wr_en_a   = 1'b0;
    bus.addr_y    = '0;
    bus.wr_en_y   = 1'b0;
    bus.clear_acc = 1'b1;
    case (r_state)
      LOAD_X: begin
        bus.s_ready = 1'b1;
        bus.wr_en_x = bus.s_valid;
        bus.addr_x  = r_in_cnt;
      end
      LOAD_A: begin
        bus.s_ready = 1'b1;
        bus.wr_en_a = bus.s_valid;
        bus.addr_a  = V_AW'(r_in_cnt);
      end
      MAC: begin
        bus.addr_x    = x_index(r_row, r_col);
        bus.addr_a    = r_col;
        bus.clear_acc = !((r_cyc >= WIN_LO) && (r_cyc <= WIN_HI));
      end
      DRAIN: bus.clear_acc = !((r_cyc >= WIN_LO) && (r_cyc <= WIN_HI));
      WRITE_Y: begin
        bus.wr_en_y = 1'b1;
        bus.addr_y  = r_row;
      end
      OUT_ADDR: bus.addr_y = r_out_cnt;
      OUT_HOLD: begin
        bus.addr_y  = r_out_cnt;
        bus.m_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mvm_controller.sv
// tb/tb_mvm_controller.sv - randomized self-checking bench for mvm_controller with a DataPath stand-in
module tb_mvm_controller;
  import mvm_pkg::*;

  localparam int LAT    = 2;
  localparam int PERIOD = N + LAT + 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic signed [7:0]  data_in = '0;
  logic signed [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  mvm_controller_if bus();

  mvm_controller #(.MAC_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // DataPath stand-in: memories, LAT-stage product pipe, accumulator, registered y read.
  logic signed [7:0]  x_mem [16];
  logic signed [7:0]  a_mem [4];
  logic signed [31:0] y_mem [4];
  logic signed [31:0] pipe  [LAT];
  logic signed [31:0] acc;

  initial begin
    for (int i = 0; i < 16; i++) x_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      a_mem[i] = '0;
      y_mem[i] = '0;
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    acc      = '0;
    data_out = '0;
  end

  always @(posedge clk) begin
    if (bus.wr_en_x) x_mem[bus.addr_x] <= data_in;
    if (bus.wr_en_a) a_mem[bus.addr_a] <= data_in;
    pipe[0] <= int'(x_mem[bus.addr_x]) * int'(a_mem[bus.addr_a]);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (bus.clear_acc) acc <= '0;
    else               acc <= acc + pipe[LAT-1];
    if (bus.wr_en_y) y_mem[bus.addr_y] <= acc;
    data_out <= y_mem[bus.addr_y];
  end

  logic signed [7:0] cur_x [X_DEPTH];
  logic signed [7:0] cur_a [N];
  int                y_ref [N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void compute_ref();
    for (int r = 0; r < N; r++) begin
      y_ref[r] = 0;
      for (int c = 0; c < N; c++) y_ref[r] += int'(cur_x[N*r+c]) * int'(cur_a[c]);
    end
  endfunction

  function automatic void set_seq();
    for (int i = 0; i < X_DEPTH; i++) cur_x[i] = 8'(i + 1);
    for (int i = 0; i < N; i++) cur_a[i] = 8'sd1;
    compute_ref();
  endfunction

  function automatic void set_rand();
    for (int i = 0; i < X_DEPTH; i++) cur_x[i] = 8'($urandom);
    for (int i = 0; i < N; i++) cur_a[i] = 8'($urandom);
    compute_ref();
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"},   bus.s_ready,   1);
    check({tag, "_m_valid"},   bus.m_valid,   0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_wr_en"},     {bus.wr_en_x, bus.wr_en_a, bus.wr_en_y}, 0);
    check({tag, "_clear_acc"}, bus.clear_acc, 1);
    check({tag, "_addrs"},     {bus.addr_x, bus.addr_a, bus.addr_y}, 0);
  endtask

  // mode 0: s_valid held, 1: toggles 1,0, 2: random gaps
  task automatic do_load(input int mode);
    int idx = 0;
    int cyc = 0;
    int nx  = 0;
    int na  = 0;
    bit v;
    while (idx < X_DEPTH + N && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.s_valid = v;
      if (idx < X_DEPTH) data_in = cur_x[idx];
      else               data_in = cur_a[idx-X_DEPTH];
      #1;
      check("load_s_ready", bus.s_ready, 1);
      check("load_busy", bus.busy, (idx != 0));
      if (idx < X_DEPTH) begin
        check("wr_en_x", bus.wr_en_x, v);
        check("addr_x_load", bus.addr_x, idx);
        check("wr_en_a_in_x", bus.wr_en_a, 0);
      end else begin
        check("wr_en_a", bus.wr_en_a, v);
        check("addr_a_load", bus.addr_a, idx - X_DEPTH);
        check("wr_en_x_in_a", bus.wr_en_x, 0);
      end
      nx += int'(bus.wr_en_x);
      na += int'(bus.wr_en_a);
      if (v) idx++;
      cyc++;
    end
    check("load_beats", idx, X_DEPTH + N);
    check("x_pulses", nx, X_DEPTH);
    check("a_pulses", na, N);
  endtask

  // Cycle c counts from the row-0 first MAC cycle; every row takes PERIOD cycles.
  task automatic run_mac(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int r;
      int m;
      @(negedge clk);
      bus.s_valid = 1'($urandom_range(0, 1));
      #1;
      r = c / PERIOD;
      m = c % PERIOD;
      check("mac_clear_acc", bus.clear_acc, !(m >= LAT && m <= LAT + 2));
      check("mac_wr_en_y",   bus.wr_en_y,   (m == PERIOD - 1));
      check("mac_addr_y",    bus.addr_y,    (m == PERIOD - 1) ? r : 0);
      check("mac_addr_x",    bus.addr_x,    (m < N) ? N*r + m : 0);
      check("mac_addr_a",    bus.addr_a,    (m < N) ? m : 0);
      check("mac_s_ready",   bus.s_ready,   0);
      check("mac_wr_en_xa",  {bus.wr_en_x, bus.wr_en_a}, 0);
      check("mac_busy",      bus.busy,      1);
      check("mac_m_valid",   bus.m_valid,   0);
    end
    bus.s_valid = 1'b0;
  endtask

  // stall < 0 picks a random stall per element
  task automatic run_out(input int stall);
    for (int k = 0; k < N; k++) begin
      int st;
      @(negedge clk);
      #1;
      check("oaddr_m_valid", bus.m_valid, 0);
      check("oaddr_addr_y",  bus.addr_y,  k);
      check("oaddr_busy",    bus.busy,    1);
      bus.m_ready = 1'($urandom_range(0, 1));
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int j = 0; j <= st; j++) begin
        @(negedge clk);
        #1;
        check("ohold_m_valid",  bus.m_valid, 1);
        check("ohold_addr_y",   bus.addr_y,  k);
        check("ohold_data_out", data_out,    y_ref[k]);
        bus.m_ready = (j == st);
      end
    end
    @(negedge clk);
    #1;
    bus.m_ready = 1'b0;
    check_idle("post_out");
  endtask

  task automatic run_case(input int mode, input int stall);
    do_load(mode);
    run_mac(N * PERIOD);
    run_out(stall);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_idle("after_reset");

    set_seq();
    run_case(0, 0);
    run_case(1, 0);
    run_case(0, 5);

    // Asynchronous reset mid row 1 MAC, then a fresh load.
    set_rand();
    do_load(2);
    run_mac(PERIOD + 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle("rst_mid_mac");
    @(negedge clk);
    #1;
    check_idle("rst_held");
    reset_n = 1'b1;
    set_seq();
    run_case(0, 1);

    for (int i = 0; i < X_DEPTH; i++) cur_x[i] = -8'sd128;
    for (int i = 0; i < N; i++) cur_a[i] = 8'sd127;
    compute_ref();
    check("signed_ref", y_ref[0], -48768);
    run_case(2, -1);

    for (int t = 0; t < 5; t++) begin
      set_rand();
      run_case(2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
